// File: rtl/c3po_reg_master.sv
// Purpose: C3PO register-port initiator; queues read/write commands and runs each as a four-phase req/ack transaction.
// Latency: a command pushed into an empty FIFO in cycle N raises sig_req in N+2; the response pulses one cycle after ack is sampled.
// Backpressure: cmd_rdy = !full (a same-cycle pop never frees a slot); responses have no backpressure.
//
// Ports:
//   sig_clock / sig_reset_L         : clock, async active-low reset
//   cmd_val/cmd_rdy/cmd_rd_wr/
//   cmd_addr/cmd_wdata              : command push interface
//   sig_addr/sig_req/sig_rd_wr/
//   sig_write_val/sig_read_val/
//   sig_ack                         : C3PO register port
//   rsp_val/rsp_rd_wr/rsp_addr/
//   rsp_data/rsp_timeout            : one response pulse per command
//   busy, timeout_cnt               : status
module c3po_reg_master #(
    parameter int ADDR_SIZE_P = 6,
    parameter int CMD_DEPTH_P = 4,
    parameter int TIMEOUT_P   = 64
) (
    input  logic                   sig_clock,
    input  logic                   sig_reset_L,
    input  logic                   cmd_val,
    output logic                   cmd_rdy,
    input  logic                   cmd_rd_wr,
    input  logic [ADDR_SIZE_P-1:0] cmd_addr,
    input  logic [31:0]            cmd_wdata,
    output logic [ADDR_SIZE_P-1:0] sig_addr,
    output logic                   sig_req,
    output logic                   sig_rd_wr,
    output logic [31:0]            sig_write_val,
    input  logic [31:0]            sig_read_val,
    input  logic                   sig_ack,
    output logic                   rsp_val,
    output logic                   rsp_rd_wr,
    output logic [ADDR_SIZE_P-1:0] rsp_addr,
    output logic [31:0]            rsp_data,
    output logic                   rsp_timeout,
    output logic                   busy,
    output logic [7:0]             timeout_cnt
);

    localparam int PTR_W  = $clog2(CMD_DEPTH_P);
    localparam int ENT_W  = 1 + ADDR_SIZE_P + 32;
    localparam int WAIT_W = (TIMEOUT_P < 2) ? 1 : $clog2(TIMEOUT_P + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT_P);
    localparam bit TO_EN = (TIMEOUT_P != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACKLOW = 2'd2
    } state_t;

    // ---------------- command FIFO ----------------
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ENT_W-1:0] fifo_mem [CMD_DEPTH_P];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head_ent;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // Ready comes from registered pointers only, so a pop in the same cycle
    // cannot make room for a push.
    assign cmd_rdy    = !fifo_full;
    assign push       = cmd_val && cmd_rdy;
    assign head_ent   = fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge sig_clock) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_rd_wr, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge sig_clock or negedge sig_reset_L) begin
        if (!sig_reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // ---------------- transaction FSM ----------------
    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                ack_hit;
    logic                to_hit;

    always_ff @(posedge sig_clock or negedge sig_reset_L) begin
        if (!sig_reset_L) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty)        state_d = ST_REQ;
            ST_REQ:    if (ack_hit || to_hit)  state_d = ST_ACKLOW;
            ST_ACKLOW: if (!sig_ack)           state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // Ack is checked before the limit, so an ack on the last wait cycle
    // still completes normally.
    always_comb begin
        pop     = 1'b0;
        ack_hit = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            ST_IDLE: pop     = !fifo_empty;
            ST_REQ: begin
                ack_hit = sig_ack;
                to_hit  = !sig_ack && TO_EN && (wait_cnt == WAIT_LIM);
            end
            default: ;
        endcase
    end

    // sig_req follows the state register, so an async reset drops it at once.
    assign sig_req = (state_q == ST_REQ);
    assign busy    = !fifo_empty || (state_q != ST_IDLE);

    // ---------------- datapath registers ----------------
    always_ff @(posedge sig_clock or negedge sig_reset_L) begin
        if (!sig_reset_L) begin
            sig_addr      <= '0;
            sig_rd_wr     <= 1'b0;
            sig_write_val <= '0;
            wait_cnt      <= '0;
            rsp_val       <= 1'b0;
            rsp_rd_wr     <= 1'b0;
            rsp_addr      <= '0;
            rsp_data      <= '0;
            rsp_timeout   <= 1'b0;
            timeout_cnt   <= '0;
        end else begin
            rsp_val <= ack_hit || to_hit;
            if (pop) begin
                sig_rd_wr     <= head_ent[ENT_W-1];
                sig_addr      <= head_ent[32 +: ADDR_SIZE_P];
                sig_write_val <= head_ent[31:0];
                wait_cnt      <= WAIT_W'(1);
            end else if (state_q == ST_REQ && wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (ack_hit) begin
                rsp_rd_wr   <= sig_rd_wr;
                rsp_addr    <= sig_addr;
                rsp_data    <= sig_rd_wr ? sig_read_val : 32'h0;
                rsp_timeout <= 1'b0;
            end else if (to_hit) begin
                rsp_rd_wr   <= sig_rd_wr;
                rsp_addr    <= sig_addr;
                rsp_data    <= 32'h0;
                rsp_timeout <= 1'b1;
                if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

endmodule
